serial_adder: RTL and testbench

Parametrised bit-serial adder, the multi-bit successor to the single-bit half adder cell. It adds two WIDTH-bit unsigned operands one bit per clock, LSB first, through a single full-adder slice and a registered carry, trading latency for area. It sits next to the combinational adder cells in the arithmetic library. It is the sequential building block for area-constrained datapaths, with a start/busy/done handshake.

---
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//
// Bit-serial unsigned adder. Two WIDTH-bit operands are added one bit per
// clock, LSB first. The datapath is a single full-adder slice with a
// registered carry. The critical path is one slice regardless of WIDTH.
//
// Handshake:
//   - A start pulse seen while idle loads the operands and raises busy.
//   - WIDTH edges later, sum/cout update, busy falls and done pulses for
//     exactly one cycle.
//   - A start in the done cycle is accepted, so operations can run back to
//     back.
//
// Optional feature, selected by the macro SERIAL_ADDER_CIN_EN:
//   - defined   : a cin port exists and seeds the carry register, so the
//                 result is a + b + cin.
//   - undefined : there is no cin port, the carry register is seeded with 0,
//                 and the result is a + b.
//
// Parameters:
//   WIDTH   operand/result width in bits, 1..64 (default 8)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request a new addition (ignored while busy)
//   a, b    operands, sampled on the accepting edge only
//   cin     carry-in (only with SERIAL_ADDER_CIN_EN)
//   busy    high while an addition is in progress
//   done    one-cycle pulse when sum/cout are updated
//   sum     result of the last completed addition
//   cout    carry-out of the last completed addition

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             carry_init;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDER_CIN_EN
    assign carry_init = cin;
`else
    assign carry_init = 1'b0;
`endif

    // Full-adder slice on the current LSBs. The new sum bit enters the result
    // register from the top, so after WIDTH shifts bit 0 ends up at the LSB.
    // The concatenate-then-slice form stays legal for WIDTH=1.
    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_cat    = {sum_bit, res_sh};
        res_next   = res_cat[WIDTH:1];
    end

    // Control FSM and datapath registers. sum/cout are written only on the
    // completion edge, so they hold the previous result throughout RUN.
    // Reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= carry_init;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= carry_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//
// Directed bench for serial_adder:
//   - an 8-bit instance drives the main handshake scenarios;
//   - a 4-bit instance covers the carry-in case.
// The expected results depend on whether SERIAL_ADDER_CIN_EN is defined.

module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
`ifdef SERIAL_ADDER_CIN_EN
    logic       cin;
    logic       cin4;
`endif

    int checkCount;
    int errorCount;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_CIN_EN
        .cin   (cin),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
`ifdef SERIAL_ADDER_CIN_EN
        .cin   (cin4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for one edge, then confirm acceptance.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB);
        start = 1'b1;
        a     = opA;
        b     = opB;
        tick();
        start = 1'b0;
        checkOutput("accept busy", 64'(busy), 64'd1);
        checkOutput("accept done", 64'(done), 64'd0);
    endtask

    // Run the 8 processing edges. Before the last edge the old result must
    // hold; done must appear exactly on edge 8. A nonzero injectAt pulses a
    // start with 0xFF operands on that edge, which must be ignored.
    task automatic finishOp(input logic [7:0] prevSum, input logic prevCout,
                            input logic [7:0] expSum, input logic expCout,
                            input int injectAt);
        for (int i = 1; i <= 8; i++) begin
            if (i == injectAt) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            tick();
            start = 1'b0;
            if (i < 8) begin
                checkOutput($sformatf("run busy e%0d", i), 64'(busy), 64'd1);
                checkOutput($sformatf("run done e%0d", i), 64'(done), 64'd0);
                checkOutput($sformatf("run sum hold e%0d", i), 64'(sum), 64'(prevSum));
                checkOutput($sformatf("run cout hold e%0d", i), 64'(cout), 64'(prevCout));
            end else begin
                checkOutput("final busy", 64'(busy), 64'd0);
                checkOutput("final done", 64'(done), 64'd1);
                checkOutput("final sum", 64'(sum), 64'(expSum));
                checkOutput("final cout", 64'(cout), 64'(expCout));
            end
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
`ifdef SERIAL_ADDER_CIN_EN
        cin    = 1'b0;
        cin4   = 1'b0;
`endif

        // Reset, then idle with no start.
        #22;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset sum", 64'(sum), 64'd0);
        checkOutput("reset cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("idle busy", 64'(busy), 64'd0);
            checkOutput("idle done", 64'(done), 64'd0);
            checkOutput("idle sum", 64'(sum), 64'd0);
            checkOutput("idle cout", 64'(cout), 64'd0);
        end

        // Carry propagation across all bits, then a mid-word carry.
        $display("[TB] carry propagation");
        applyStimulus(8'hFF, 8'h01);
        finishOp(8'h00, 1'b0, 8'h00, 1'b1, 0);
        tick();
        checkOutput("done one-shot", 64'(done), 64'd0);
        applyStimulus(8'h0F, 8'h01);
        finishOp(8'h00, 1'b1, 8'h10, 1'b0, 0);
        tick();

        // A start while busy is ignored and never queued.
        $display("[TB] ignored start");
        applyStimulus(8'h12, 8'h34);
        finishOp(8'h10, 1'b0, 8'h46, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no queued busy", 64'(busy), 64'd0);
            checkOutput("no queued done", 64'(done), 64'd0);
            checkOutput("no queued sum", 64'(sum), 64'h46);
        end

        // Back to back: start is held in the done cycle of the first add.
        $display("[TB] back-to-back");
        applyStimulus(8'h80, 8'h80);
        finishOp(8'h46, 1'b0, 8'h00, 1'b1, 0);
        applyStimulus(8'h01, 8'h02);
        finishOp(8'h00, 1'b1, 8'h03, 1'b0, 0);
        tick();

        // Reset during RUN aborts the add at once, with no done pulse.
        $display("[TB] reset mid-operation");
        applyStimulus(8'hAA, 8'h55);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort sum", 64'(sum), 64'd0);
        checkOutput("abort cout", 64'(cout), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("post-abort done", 64'(done), 64'd0);
            checkOutput("post-abort busy", 64'(busy), 64'd0);
        end
        applyStimulus(8'h01, 8'h01);
        finishOp(8'h00, 1'b0, 8'h02, 1'b0, 0);
        tick();

        // Carry-in on the 4-bit instance: 0xF + 0x0 (+ cin when present).
        $display("[TB] carry-in width 4");
        start4 = 1'b1;
        a4     = 4'hF;
        b4     = 4'h0;
`ifdef SERIAL_ADDER_CIN_EN
        cin4   = 1'b1;
`endif
        tick();
        start4 = 1'b0;
        a4     = 4'h0;
`ifdef SERIAL_ADDER_CIN_EN
        cin4   = 1'b0;
`endif
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput("w4 busy", 64'(busy4), 64'd1);
            checkOutput("w4 done", 64'(done4), 64'd0);
        end
        tick();
        checkOutput("w4 final done", 64'(done4), 64'd1);
        checkOutput("w4 final busy", 64'(busy4), 64'd0);
`ifdef SERIAL_ADDER_CIN_EN
        checkOutput("w4 sum", 64'(sum4), 64'h0);
        checkOutput("w4 cout", 64'(cout4), 64'd1);
`else
        checkOutput("w4 sum", 64'(sum4), 64'hF);
        checkOutput("w4 cout", 64'(cout4), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
